// File: rtl/pool_pkg.sv
// Shared constants, state encoding and tap-offset helper for the pooling-1 read path.
package pool_pkg;

    localparam int IMG_W  = 24;
    localparam int POOL_W = IMG_W / 2;
    localparam int N_WIN  = (IMG_W / 2) * (IMG_W / 4);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WIN   = 3'd3,
        FIN   = 3'd4
    } c1rd_state_t;

    // Offset of a 2x2 window tap from its top-left base address.
    function automatic int unsigned tap_off(input logic [1:0] tap, input int unsigned img_w);
        case (tap)
            2'd0:    return 32'd0;
            2'd1:    return 32'd1;
            2'd2:    return img_w;
            2'd3:    return img_w + 32'd1;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/c1_tap_pipe.sv
// Delays the tap issue strobe and tap number by the conv-1 memory read latency.
module c1_tap_pipe #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [1:0] idx_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    logic [2:0] pipe_q [LAT];

    // Shift register of {valid, idx}; keeps moving regardless of enable so in-flight taps drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= 3'd0;
            end
        end else begin
            pipe_q[0] <= {valid_i, idx_i};
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {valid_o, idx_o} = pipe_q[LAT-1];

endmodule

// File: rtl/c1_pool_read.sv
// Walks the 24x24 conv-1 map in 2x2 windows on two lanes (top/bottom half) and
// hands each completed window to the pooling max unit.
module c1_pool_read
    import pool_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic              tap_valid,
    output logic [1:0]        tap_idx,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              done
);

    localparam int          HALF     = IMG_W * IMG_W / 2;
    localparam int          WIN_W    = $clog2(N_WIN);
    localparam logic [1:0]  LAT_LAST = 2'(MEM_LAT - 1);

    c1rd_state_t       state_q;
    logic [1:0]        tap_q;
    logic [1:0]        lat_q;
    logic [3:0]        pc_q;
    logic [WIN_W-1:0]  win_q;
    logic [ADDR_W-1:0] base0_q, base1_q, base0_d, base1_d;
    logic [ADDR_W-1:0] addr0_q, addr1_q;
    logic              win_valid_q, done_q;
    logic [ADDR_W-1:0] step_s, next_off_s;
    logic              issue_s;

    // Base stride: next column pair, or skip the odd row at the end of a pool row.
    always_comb begin
        step_s = ADDR_W'(2);
        if (pc_q == 4'(POOL_W - 1)) begin
            step_s = ADDR_W'(IMG_W + 2);
        end else begin
            step_s = ADDR_W'(2);
        end
    end

    assign base0_d    = base0_q + step_s;
    assign base1_d    = base1_q + step_s;
    assign next_off_s = ADDR_W'(tap_off(tap_q + 2'd1, IMG_W));
    assign issue_s    = (state_q == ISSUE) && enable;

    // Window FSM with counters, bases and registered addresses/handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tap_q       <= 2'd0;
            lat_q       <= 2'd0;
            pc_q        <= 4'd0;
            win_q       <= '0;
            base0_q     <= '0;
            base1_q     <= ADDR_W'(HALF);
            addr0_q     <= '0;
            addr1_q     <= ADDR_W'(HALF);
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && !done_q) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (enable) begin
                        if (tap_q == 2'd3) begin
                            state_q <= DRAIN;
                            lat_q   <= 2'd0;
                        end else begin
                            tap_q   <= tap_q + 2'd1;
                            addr0_q <= base0_q + next_off_s;
                            addr1_q <= base1_q + next_off_s;
                        end
                    end
                end
                DRAIN: begin
                    if (lat_q == LAT_LAST) begin
                        state_q     <= WIN;
                        win_valid_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                WIN: begin
                    if (win_ready) begin
                        win_valid_q <= 1'b0;
                        if (win_q == WIN_W'(N_WIN - 1)) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            win_q   <= win_q + 1'b1;
                            tap_q   <= 2'd0;
                            pc_q    <= (pc_q == 4'(POOL_W - 1)) ? 4'd0 : pc_q + 4'd1;
                            base0_q <= base0_d;
                            base1_q <= base1_d;
                            addr0_q <= base0_d;
                            addr1_q <= base1_d;
                        end
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    c1_tap_pipe #(
        .LAT(MEM_LAT)
    ) u_tap_pipe (
        .clk    (clk),
        .rst    (reset),
        .valid_i(issue_s),
        .idx_i  (tap_q),
        .valid_o(tap_valid),
        .idx_o  (tap_idx)
    );

    assign rd_addr0  = addr0_q;
    assign rd_addr1  = addr1_q;
    assign win_valid = win_valid_q;
    assign done      = done_q;

endmodule
